// File: rtl/console_cursor_ctrl.sv
// Terminal-style write sequencer for the text console buffer.
// Interprets a byte stream (printables and a few control codes), tracks the
// cursor, and runs scroll-up / clear-screen as one-cell-per-cycle sequences.
module console_cursor_ctrl #(
    parameter int          NUM_ROWS   = 3,
    parameter int          NUM_COLS   = 10,
    parameter int          ADDR_WIDTH = 5,
    parameter logic [6:0]  FILL_CHAR  = 7'h20,
    localparam int         ROW_W      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int         COL_W      = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  buf_we,
    output logic [ADDR_WIDTH-1:0] buf_waddr,
    output logic [6:0]            buf_wdata,
    output logic [ADDR_WIDTH-1:0] buf_raddr,
    input  logic [6:0]            buf_rdata,
    output logic [ROW_W-1:0]      cursor_row,
    output logic [COL_W-1:0]      cursor_col,
    output logic                  busy
);

    localparam int N_CELLS = NUM_ROWS * NUM_COLS;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX     = ADDR_WIDTH'(N_CELLS - 1);
    localparam logic [ADDR_WIDTH-1:0] SCROLL_SPLIT = ADDR_WIDTH'(N_CELLS - NUM_COLS);
    localparam logic [ADDR_WIDTH-1:0] COLS_A       = ADDR_WIDTH'(NUM_COLS);
    localparam logic [COL_W-1:0]      COL_LAST     = COL_W'(NUM_COLS - 1);
    localparam logic [ROW_W-1:0]      ROW_LAST     = ROW_W'(NUM_ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_CLEAR  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [6:0]              wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0]   raddr;
    logic [ADDR_WIDTH-1:0]   cursor_addr;
    logic                    printable;

    assign cursor_addr = ADDR_WIDTH'(row_q) * COLS_A + ADDR_WIDTH'(col_q);
    assign printable   = (in_data >= 8'h20) && (in_data <= 8'h7E);

    // State, cursor and registered write port; reset starts a full clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            col_q   <= col_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Byte interpretation in IDLE and the cell-by-cell scroll/clear walkers.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        row_d   = row_q;
        col_d   = col_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        raddr   = '0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (printable) begin
                        we_d    = 1'b1;
                        waddr_d = cursor_addr;
                        wdata_d = in_data[6:0];
                        if (col_q != COL_LAST) begin
                            col_d = col_q + COL_W'(1);
                        end else begin
                            col_d = '0;
                            if (row_q != ROW_LAST) row_d = row_q + ROW_W'(1);
                            else                   state_d = ST_SCROLL;
                        end
                    end else begin
                        case (in_data)
                            8'h0A: begin
                                col_d = '0;
                                if (row_q != ROW_LAST) row_d = row_q + ROW_W'(1);
                                else                   state_d = ST_SCROLL;
                            end
                            8'h0D: col_d = '0;
                            8'h08: if (col_q != '0) col_d = col_q - COL_W'(1);
                            8'h0C: begin
                                row_d   = '0;
                                col_d   = '0;
                                state_d = ST_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            ST_SCROLL: begin
                // Reads run one row ahead of writes, so no cell is read after
                // it has been overwritten.
                we_d    = 1'b1;
                waddr_d = idx_q;
                if (idx_q < SCROLL_SPLIT) begin
                    raddr   = idx_q + COLS_A;
                    wdata_d = buf_rdata;
                end else begin
                    wdata_d = FILL_CHAR;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + ADDR_WIDTH'(1);
                end
            end

            ST_CLEAR: begin
                we_d    = 1'b1;
                waddr_d = idx_q;
                wdata_d = FILL_CHAR;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + ADDR_WIDTH'(1);
                end
            end

            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = ~in_ready;
    assign buf_we     = we_q;
    assign buf_waddr  = waddr_q;
    assign buf_wdata  = wdata_q;
    assign buf_raddr  = raddr;
    assign cursor_row = row_q;
    assign cursor_col = col_q;

endmodule
